// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with rename/commit regfile writes, CDB capture and operand forwarding.
// Define ROB_WB_BYPASS_EN to let operand queries also hit the CDB result of the current cycle.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_has_rd,
  input  logic [4:0]       issue_rd,
  input  logic             issue_is_store,
  input  logic             issue_is_br,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_val,
  input  logic             wb_mispred,
  input  logic [31:0]      wb_target,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  output logic             rd_in_flag,
  output logic [4:0]       rd_in_a,
  output logic [TAG_W-1:0] rd_in_rob,
  output logic             rd_out_flag,
  output logic [4:0]       rd_out_a,
  output logic [31:0]      rd_out_val,
  output logic [TAG_W-1:0] rd_out_rob,
  output logic             store_commit,
  output logic             flush_out,
  output logic [31:0]      flush_pc
);
  localparam int CW = TAG_W + 1;
  logic [TAG_W-1:0] head, tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] busy, done, has_rd, is_store, is_br, mispred;
  logic [4:0]       rd     [DEPTH];
  logic [31:0]      val    [DEPTH];
  logic [31:0]      target [DEPTH];
  logic issue_fire, wb_fire, fire, flush_now;
  logic st1, st2, byp1, byp2;
  assign issue_ready = count != CW'(DEPTH) && !flush_out;
  assign issue_fire  = rdy && issue_valid && issue_ready;
  assign wb_fire     = rdy && wb_valid && busy[wb_tag] && !flush_out;
  assign fire        = rdy && count != '0 && done[head] && !flush_out;
  assign flush_now   = fire && is_br[head] && mispred[head];
  assign issue_tag   = tail;
  assign rd_in_flag  = issue_fire && issue_has_rd && issue_rd != 5'd0;
  assign rd_in_a     = issue_rd;
  assign rd_in_rob   = tail;
  assign rd_out_flag = fire && has_rd[head] && rd[head] != 5'd0;
  assign rd_out_a    = rd[head];
  assign rd_out_val  = val[head];
  assign rd_out_rob  = head;
  assign store_commit = fire && is_store[head];
  assign st1 = busy[q1_tag] && done[q1_tag];
  assign st2 = busy[q2_tag] && done[q2_tag];
`ifdef ROB_WB_BYPASS_EN
  assign byp1 = wb_valid && wb_tag == q1_tag;
  assign byp2 = wb_valid && wb_tag == q2_tag;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  always_comb begin
    q1_ready = st1 || byp1;
    q2_ready = st2 || byp2;
    q1_val   = st1 ? val[q1_tag] : byp1 ? wb_val : '0;
    q2_val   = st2 ? val[q2_tag] : byp2 ? wb_val : '0;
  end
  // A mispredicted branch clears the window at its own retire edge; the flush cycle then only blocks issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      busy      <= '0;
      done      <= '0;
      has_rd    <= '0;
      is_store  <= '0;
      is_br     <= '0;
      mispred   <= '0;
      flush_out <= 1'b0;
      flush_pc  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd[i]     <= '0;
        val[i]    <= '0;
        target[i] <= '0;
      end
    end else if (rdy) begin
      flush_out <= flush_now;
      if (flush_now) begin
        flush_pc <= target[head];
        busy     <= '0;
        done     <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (wb_fire) begin
          done[wb_tag]    <= 1'b1;
          val[wb_tag]     <= wb_val;
          mispred[wb_tag] <= wb_mispred;
          target[wb_tag]  <= wb_target;
        end
        if (fire) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        if (issue_fire) begin
          busy[tail]     <= 1'b1;
          done[tail]     <= 1'b0;
          has_rd[tail]   <= issue_has_rd;
          rd[tail]       <= issue_rd;
          is_store[tail] <= issue_is_store;
          is_br[tail]    <= issue_is_br;
          mispred[tail]  <= 1'b0;
          tail           <= tail + 1'b1;
        end
        count <= count + CW'(issue_fire) - CW'(fire);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic checked against a queue-based ROB model.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  logic clk = 0, rst_n = 0, rdy = 0;
  logic issue_valid = 0, issue_has_rd = 0, issue_is_store = 0, issue_is_br = 0;
  logic [4:0] issue_rd = 0;
  logic issue_ready;
  logic [3:0] issue_tag;
  logic wb_valid = 0, wb_mispred = 0;
  logic [3:0] wb_tag = 0, q1_tag = 0, q2_tag = 0;
  logic [31:0] wb_val = 0, wb_target = 0;
  logic q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic rd_in_flag, rd_out_flag, store_commit, flush_out;
  logic [4:0] rd_in_a, rd_out_a;
  logic [3:0] rd_in_rob, rd_out_rob;
  logic [31:0] rd_out_val, flush_pc;
  int n_checks = 0, n_errors = 0;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_has_rd(issue_has_rd),
    .issue_rd(issue_rd), .issue_is_store(issue_is_store), .issue_is_br(issue_is_br),
    .issue_tag(issue_tag), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .wb_mispred(wb_mispred), .wb_target(wb_target), .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_val(q1_val), .q2_val(q2_val),
    .rd_in_flag(rd_in_flag), .rd_in_a(rd_in_a), .rd_in_rob(rd_in_rob),
    .rd_out_flag(rd_out_flag), .rd_out_a(rd_out_a), .rd_out_val(rd_out_val),
    .rd_out_rob(rd_out_rob), .store_commit(store_commit), .flush_out(flush_out),
    .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag; bit has_rd; logic [4:0] rd; bit st, br, done, mp;
    logic [31:0] val, tgt;
  } ent_t;
  ent_t q[$];
  int m_tail = 0;
  bit m_flush = 0;
  logic [31:0] m_fpc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void qexp(input logic [3:0] t, output bit r, output logic [31:0] v);
    r = 0; v = 0;
    foreach (q[i]) if (q[i].tag == t && q[i].done) begin r = 1; v = q[i].val; end
`ifdef ROB_WB_BYPASS_EN
    if (!r && wb_valid && wb_tag == t) begin r = 1; v = wb_val; end
`endif
  endfunction

  task automatic model_reset();
    q.delete(); m_tail = 0; m_flush = 0; m_fpc = 0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_has_rd = 0; issue_rd = 0; issue_is_store = 0; issue_is_br = 0;
    wb_valid = 0; wb_tag = 0; wb_val = 0; wb_mispred = 0; wb_target = 0;
  endtask

  // One clock: compare combinational outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    ent_t h, n;
    bit e_rdy, e_if, e_fire, e_out, r;
    logic [31:0] v;
    @(negedge clk);
    e_rdy = q.size() != DEPTH && !m_flush;
    e_if = rdy && issue_valid && e_rdy;
    e_fire = 0;
    if (q.size() > 0) begin h = q[0]; e_fire = rdy && !m_flush && h.done; end
    e_out = e_fire && h.has_rd && h.rd != 0;
    check("issue_ready", issue_ready, e_rdy);
    check("issue_tag", issue_tag, m_tail);
    check("rd_in_flag", rd_in_flag, e_if && issue_has_rd && issue_rd != 0);
    if (e_if) begin
      check("rd_in_a", rd_in_a, issue_rd);
      check("rd_in_rob", rd_in_rob, m_tail);
    end
    check("rd_out_flag", rd_out_flag, e_out);
    if (e_out) begin
      check("rd_out_a", rd_out_a, h.rd);
      check("rd_out_val", rd_out_val, h.val);
      check("rd_out_rob", rd_out_rob, h.tag);
    end
    check("store_commit", store_commit, e_fire && h.st);
    check("flush_out", flush_out, m_flush);
    check("flush_pc", flush_pc, m_fpc);
    qexp(q1_tag, r, v);
    check("q1_ready", q1_ready, r);
    check("q1_val", q1_val, v);
    qexp(q2_tag, r, v);
    check("q2_ready", q2_ready, r);
    check("q2_val", q2_val, v);
    if (rdy) begin
      if (wb_valid && !m_flush)
        foreach (q[i]) if (q[i].tag == wb_tag) begin
          q[i].done = 1; q[i].val = wb_val; q[i].mp = wb_mispred; q[i].tgt = wb_target;
        end
      if (e_fire) void'(q.pop_front());
      m_flush = e_fire && h.br && h.mp;
      if (m_flush) begin
        q.delete(); m_tail = 0; m_fpc = h.tgt;
      end else if (e_if) begin
        n.tag = 4'(m_tail); n.has_rd = issue_has_rd; n.rd = issue_rd; n.st = issue_is_store;
        n.br = issue_is_br; n.done = 0; n.mp = 0; n.val = 0; n.tgt = 0;
        q.push_back(n);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0; #1;
    model_reset();
    check("rst_issue_tag", issue_tag, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_flush_out", flush_out, 0);
    check("rst_rd_out_flag", rd_out_flag, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit has, input logic [4:0] r, input bit st, input bit br);
    issue_valid = 1; issue_has_rd = has; issue_rd = r; issue_is_store = st; issue_is_br = br;
  endtask

  task automatic wb(input logic [3:0] t, input logic [31:0] v, input bit mp, input logic [31:0] tg);
    wb_valid = 1; wb_tag = t; wb_val = v; wb_mispred = mp; wb_target = tg;
  endtask

  task automatic drain();
    int pend[$];
    for (int c = 0; c < 300 && (q.size() > 0 || m_flush); c++) begin
      idle();
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(i);
      if (pend.size() > 0) wb(q[pend[$urandom_range(pend.size()-1)]].tag, $urandom, 0, 0);
      step();
    end
    check("drain_done", q.size(), 0);
  endtask

  initial begin
    rdy = 1;
    #2 do_reset();
    // 1: simple rename + retire
    issue(1, 5, 0, 0); step();
    idle(); wb(0, 32'h1234, 0, 0); step();
    idle(); step();
    // 2: fill the window, then a retire does not open a slot in the same cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin issue(1, 5'(i + 1), 0, 0); step(); end
    issue(1, 7, 0, 0); step();
    wb(0, 32'hAA, 0, 0); step();
    wb_valid = 0; step();
    step();
    idle(); drain();
    // 3: out-of-order writeback, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) begin issue(1, 5'(10 + i), i == 1, 0); step(); end
    idle();
    for (int t = 2; t >= 0; t--) begin wb(4'(t), 32'(100 + t), 0, 0); step(); end
    idle(); repeat (4) step();
    // 4: mispredicted branch flushes younger work
    do_reset();
    issue(1, 1, 0, 0); step();
    issue(0, 0, 0, 1); step();
    issue(1, 3, 0, 0); step();
    idle(); wb(2, 32'h22, 0, 0); step();
    wb(1, 32'h11, 1, 32'h80); step();
    wb(0, 32'h00, 0, 0); step();
    idle(); repeat (4) step();
    // 5: same-cycle query of a writeback
    do_reset();
    for (int i = 0; i < 4; i++) begin issue(1, 5'(20 + i), 0, 0); step(); end
    idle(); q1_tag = 3; q2_tag = 3; wb(3, 7, 0, 0); step();
    idle(); step();
    drain();
    // 6: freeze with a ready head, then asynchronous reset mid-stream
    do_reset();
    issue(1, 9, 1, 0); step();
    idle(); wb(0, 32'h55, 0, 0); step();
    idle(); rdy = 0; repeat (3) step();
    rdy = 1; step();
    for (int i = 0; i < 5; i++) begin issue(1, 5'(i), 0, 0); step(); end
    idle(); #2 do_reset();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rdy = $urandom_range(9) != 0;
      issue_valid = $urandom_range(1); issue_has_rd = $urandom_range(3) != 0;
      issue_rd = 5'($urandom); issue_is_store = $urandom_range(4) == 0;
      issue_is_br = $urandom_range(4) == 0;
      wb_valid = $urandom_range(9) < 6;
      wb_tag = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size()-1)].tag : 4'($urandom);
      wb_val = $urandom; wb_mispred = $urandom_range(9) == 0; wb_target = $urandom;
      q1_tag = 4'($urandom); q2_tag = 4'($urandom);
      step();
    end
    rdy = 1; drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
